dbg_run_ctrl: RTL and testbench

- Parametrised run/step/reset controller between the board inputs (RSTN, matrix-button results) and the pipelined CPU core.
- Generalises the fixed 16-bit reset shift chain and the raw step/interrupt button taps into one block. It provides a stretched core reset, per-channel debounce with press pulses, a RUN/HALT/STEP clock-enable state machine with a PC breakpoint, and a held interrupt-request handshake.
- Sits in the top level, clocked by the CPU clock; its outputs drive the core's rst, clock enable and interrupter inputs.

---
 rtl/dbg_run_ctrl_pkg.sv | 16 +
 rtl/btn_debounce.sv | 47 ++++
 rtl/dbg_run_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dbg_run_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_run_ctrl_pkg.sv
// Shared encodings for the run/step/reset debug controller: FSM states and
// the default assignment of matrix-button channels.
package dbg_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } run_state_e;

  localparam int DEF_RUN_IDX  = 0;
  localparam int DEF_STEP_IDX = 1;
  localparam int DEF_IRQ_IDX  = 2;

endpackage

// File: rtl/btn_debounce.sv
// Single-channel button debouncer: the level follows the input once it has
// been stable for DEBOUNCE cycles; press pulses on each accepted 0->1 edge.
module btn_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic          r_sync;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // The counter only runs while the sampled input disagrees with the level,
  // so any bounce back to the old level restarts the stability window.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= raw;
      r_press <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_sync;
        r_press <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/dbg_run_ctrl.sv
// Run/halt/step controller for the pipelined core: stretched reset, debounced
// buttons, clock-enable FSM with PC breakpoint, and a held interrupt request.
module dbg_run_ctrl
  import dbg_run_ctrl_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int DEBOUNCE    = 16,
  parameter int RST_LEN     = 16,
  parameter int STEP_CYCLES = 1,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 32,
  parameter int RUN_IDX     = DEF_RUN_IDX,
  parameter int STEP_IDX    = DEF_STEP_IDX,
  parameter int IRQ_IDX     = DEF_IRQ_IDX
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_BTN-1:0]  btn_raw,
  input  logic              debug_en,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  input  logic              irq_ack,
  output logic              rst_out,
  output logic              cpu_en,
  output logic              halted,
  output logic [N_BTN-1:0]  btn_level,
  output logic [N_BTN-1:0]  btn_press,
  output logic              irq_req,
  output logic [CNT_W-1:0]  step_count
);

  localparam int RCW = $clog2(RST_LEN + 1);
  localparam int SCW = $clog2(STEP_CYCLES + 1);

  logic [RCW-1:0]   r_rst_cnt;
  logic             r_rst_out;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press_raw;
  logic [N_BTN-1:0] w_press;
  logic             w_run_press;
  logic             w_step_press;
  logic             w_irq_press;
  logic             w_bp_hit;
  run_state_e       r_state;
  logic             r_cpu_en;
  logic             r_halted;
  logic             r_skip_bp;
  logic [SCW-1:0]   r_step_left;
  logic [CNT_W-1:0] r_step_count;
  logic             r_irq_req;

  // rst_out drops on the cycle after the counter has been seen at zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rst_cnt <= RCW'(RST_LEN);
      r_rst_out <= 1'b1;
    end else begin
      if (r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - RCW'(1);
      r_rst_out <= (r_rst_cnt != '0);
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk   (clk),
      .rstn  (rstn),
      .raw   (btn_raw[g]),
      .level (w_level[g]),
      .press (w_press_raw[g])
    );
  end

  assign w_press      = r_rst_out ? '0 : w_press_raw;
  assign w_run_press  = w_press[RUN_IDX];
  assign w_step_press = w_press[STEP_IDX];
  assign w_irq_press  = w_press[IRQ_IDX];
  assign w_bp_hit     = debug_en && bp_en && (pc == bp_addr) && !r_skip_bp;

  // r_skip_bp lets the first RUN cycle after a resume execute the
  // instruction sitting on the breakpoint instead of halting again.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= ST_RESET;
      r_cpu_en    <= 1'b0;
      r_halted    <= 1'b0;
      r_skip_bp   <= 1'b0;
      r_step_left <= '0;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (!r_rst_out) begin
            if (debug_en) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state  <= ST_RUN;
              r_cpu_en <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_skip_bp <= 1'b0;
          if ((debug_en && w_run_press) || w_bp_hit) begin
            r_state  <= ST_HALT;
            r_cpu_en <= 1'b0;
            r_halted <= 1'b1;
          end
        end
        ST_HALT: begin
          if (!debug_en || w_run_press) begin
            r_state   <= ST_RUN;
            r_cpu_en  <= 1'b1;
            r_halted  <= 1'b0;
            r_skip_bp <= 1'b1;
          end else if (w_step_press) begin
            r_state     <= ST_STEP;
            r_cpu_en    <= 1'b1;
            r_halted    <= 1'b0;
            r_step_left <= SCW'(STEP_CYCLES);
          end
        end
        ST_STEP: begin
          if (r_step_left <= SCW'(1)) begin
            r_state  <= ST_HALT;
            r_cpu_en <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_step_left <= r_step_left - SCW'(1);
          end
        end
        default: begin
          r_state  <= ST_RESET;
          r_cpu_en <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_step_count <= '0;
    else if (r_cpu_en) r_step_count <= r_step_count + CNT_W'(1);
  end

  // irq_req/irq_ack: the request rises on a press and holds until irq_ack
  // is sampled with it high; a press on the ack cycle keeps it raised.
  always_ff @(posedge clk) begin
    if (!rstn) r_irq_req <= 1'b0;
    else if (w_irq_press) r_irq_req <= 1'b1;
    else if (irq_ack) r_irq_req <= 1'b0;
  end

  assign rst_out    = r_rst_out;
  assign cpu_en     = r_cpu_en;
  assign halted     = r_halted;
  assign btn_level  = w_level;
  assign btn_press  = w_press;
  assign irq_req    = r_irq_req;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Bench for dbg_run_ctrl: reset stretch, debounce timing, step, breakpoint,
// run/step priority, IRQ handshake and reset during a step.
module tb_dbg_run_ctrl;

  localparam int N_BTN       = 4;
  localparam int DEBOUNCE    = 16;
  localparam int RST_LEN     = 16;
  localparam int STEP_CYCLES = 3;
  localparam int ADDR_W      = 32;
  localparam int CNT_W       = 32;
  localparam int RUN_IDX     = 0;
  localparam int STEP_IDX    = 1;
  localparam int IRQ_IDX     = 2;
  localparam int EXP_W       = 3 + CNT_W;

  localparam logic [N_BTN-1:0] M_RUN  = N_BTN'(1) << RUN_IDX;
  localparam logic [N_BTN-1:0] M_STEP = N_BTN'(1) << STEP_IDX;
  localparam logic [N_BTN-1:0] M_IRQ  = N_BTN'(1) << IRQ_IDX;

  logic              clk;
  logic              rstn;
  logic [N_BTN-1:0]  btn_raw;
  logic              debug_en;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] pc;
  logic              irq_ack;
  logic              rst_out;
  logic              cpu_en;
  logic              halted;
  logic [N_BTN-1:0]  btn_level;
  logic [N_BTN-1:0]  btn_press;
  logic              irq_req;
  logic [CNT_W-1:0]  step_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] e_bit;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              irq_ack;
    logic              cpu_en;
    logic              halted;
    logic              irq_req;
    logic [CNT_W-1:0]  cnt;
  } vec_t;

  vec_t vecs[14];

  dbg_run_ctrl #(
    .N_BTN(N_BTN), .DEBOUNCE(DEBOUNCE), .RST_LEN(RST_LEN),
    .STEP_CYCLES(STEP_CYCLES), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .RUN_IDX(RUN_IDX), .STEP_IDX(STEP_IDX), .IRQ_IDX(IRQ_IDX)
  ) dut (
    .clk(clk), .rstn(rstn), .btn_raw(btn_raw), .debug_en(debug_en),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .irq_ack(irq_ack),
    .rst_out(rst_out), .cpu_en(cpu_en), .halted(halted),
    .btn_level(btn_level), .btn_press(btn_press), .irq_req(irq_req),
    .step_count(step_count)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [ADDR_W-1:0] p, input logic ack, input logic c,
                              input logic h, input logic i, input int n);
    vec_t v;
    v.pc = p; v.irq_ack = ack; v.cpu_en = c; v.halted = h; v.irq_req = i;
    v.cnt = CNT_W'(n);
    return v;
  endfunction

  // Scoreboard: expected outputs queued at drive time, popped after the edge.
  task automatic apply_vec(input int i, input logic [CNT_W-1:0] base);
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] a;
    pc      = vecs[i].pc;
    irq_ack = vecs[i].irq_ack;
    exp_q.push_back({vecs[i].cpu_en, vecs[i].halted, vecs[i].irq_req, vecs[i].cnt + base});
    tick;
    e = exp_q.pop_front();
    a = {cpu_en, halted, irq_req, step_count};
    check($sformatf("vec%0d", i), 64'(a), 64'(e));
    irq_ack = 1'b0;
  endtask

  // Returns on the cycle the press pulse is visible; the next edge acts on it.
  task automatic press(input logic [N_BTN-1:0] m);
    repeat (20) tick;
    btn_raw = m;
    repeat (DEBOUNCE + 1) tick;
    check("press_pulse", 64'(btn_press), 64'(m));
    btn_raw = '0;
  endtask

  task automatic do_reset(input logic dbg);
    debug_en = dbg;
    rstn = 1'b0;
    repeat (3) tick;
    rstn = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk(32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 0);
    vecs[1]  = mk(32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1);
    vecs[2]  = mk(32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 2);
    vecs[3]  = mk(32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 3);
    vecs[4]  = mk(32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 3);
    vecs[5]  = mk(32'h30, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    vecs[6]  = mk(32'h38, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    vecs[7]  = mk(32'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    vecs[8]  = mk(32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    vecs[9]  = mk(32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 3);
    vecs[10] = mk(32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    vecs[11] = mk(32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    vecs[12] = mk(32'h44, 1'b0, 1'b1, 1'b0, 1'b0, 5);
    vecs[13] = mk(32'h48, 1'b0, 1'b1, 1'b0, 1'b0, 6);

    rstn = 1'b0; btn_raw = '0; debug_en = 1'b0; bp_en = 1'b0;
    bp_addr = 32'h40; pc = '0; irq_ack = 1'b0;

    // Reset values and reset stretch, free-running mode
    repeat (3) tick;
    check("rst_rst_out", 64'(rst_out), 64'(1));
    check("rst_cpu_en", 64'(cpu_en), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_irq_req", 64'(irq_req), 64'(0));
    check("rst_step_count", 64'(step_count), 64'(0));
    check("rst_btn_level", 64'(btn_level), 64'(0));
    check("rst_btn_press", 64'(btn_press), 64'(0));
    rstn = 1'b1;
    for (int k = 0; k < RST_LEN; k++) begin
      tick;
      check($sformatf("rst_hold%0d", k), 64'(rst_out), 64'(1));
    end
    tick;
    check("rst_release", 64'(rst_out), 64'(0));
    check("rst_release_cpu_en", 64'(cpu_en), 64'(0));
    tick;
    check("run_after_rst", 64'(cpu_en), 64'(1));
    check("run_after_rst_halted", 64'(halted), 64'(0));

    // Bouncing step button, then held: one pulse DEBOUNCE+1 cycles later
    for (int i = 0; i <= 70; i++) begin
      btn_raw[STEP_IDX] = (i < 40) ? (((i / 5) % 2) == 0) : 1'b1;
      exp_q.push_back(EXP_W'(i == 40 + DEBOUNCE));
      tick;
      e_bit = exp_q.pop_front();
      check($sformatf("bounce_press%0d", i), 64'(btn_press[STEP_IDX]), 64'(e_bit[0]));
    end
    check("bounce_level", 64'(btn_level[STEP_IDX]), 64'(1));
    check("run_ignores_step", 64'({cpu_en, halted}), 64'(2'b10));
    btn_raw = '0;

    // Debug reset lands in HALT
    do_reset(1'b1);
    repeat (RST_LEN + 2) tick;
    check("dbg_rst_halted", 64'({cpu_en, halted}), 64'(2'b01));
    check("dbg_rst_count", 64'(step_count), 64'(0));

    // Single step of STEP_CYCLES cycles
    press(M_STEP);
    for (int i = 0; i <= 4; i++) apply_vec(i, '0);

    // Breakpoint halt and resume past it
    bp_en = 1'b1;
    pc = 32'h30;
    press(M_RUN);
    for (int i = 5; i <= 9; i++) apply_vec(i, CNT_W'(3));
    press(M_RUN);
    for (int i = 10; i <= 13; i++) apply_vec(i, CNT_W'(3));

    // Run press halts; run and step together resumes RUN
    pc = 32'h100;
    press(M_RUN);
    tick;
    check("run_press_halt", 64'({cpu_en, halted}), 64'(2'b01));
    press(M_RUN | M_STEP);
    tick;
    check("run_wins", 64'({cpu_en, halted}), 64'(2'b10));
    repeat (STEP_CYCLES + 2) tick;
    check("run_wins_hold", 64'({cpu_en, halted}), 64'(2'b10));

    // Leaving debug mode releases HALT
    press(M_RUN);
    tick;
    check("halt_again", 64'(halted), 64'(1));
    debug_en = 1'b0;
    tick;
    check("dbg_off_run", 64'({cpu_en, halted}), 64'(2'b10));
    debug_en = 1'b1;

    // IRQ handshake
    press(M_IRQ);
    check("irq_before_edge", 64'(irq_req), 64'(0));
    tick;
    check("irq_set", 64'(irq_req), 64'(1));
    for (int k = 0; k < 10; k++) begin
      tick;
      check($sformatf("irq_hold%0d", k), 64'(irq_req), 64'(1));
    end
    irq_ack = 1'b1;
    tick;
    irq_ack = 1'b0;
    check("irq_ack_clear", 64'(irq_req), 64'(0));
    irq_ack = 1'b1;
    tick;
    irq_ack = 1'b0;
    check("irq_ack_idle", 64'(irq_req), 64'(0));
    press(M_IRQ);
    tick;
    check("irq_set2", 64'(irq_req), 64'(1));
    press(M_IRQ);
    tick;
    check("irq_press_dropped", 64'(irq_req), 64'(1));
    irq_ack = 1'b1;
    tick;
    irq_ack = 1'b0;
    check("irq_ack_clear2", 64'(irq_req), 64'(0));
    tick;
    check("irq_no_requeue", 64'(irq_req), 64'(0));
    press(M_IRQ);
    tick;
    check("irq_set3", 64'(irq_req), 64'(1));
    press(M_IRQ);
    irq_ack = 1'b1;
    tick;
    irq_ack = 1'b0;
    check("irq_ack_and_press", 64'(irq_req), 64'(1));
    tick;
    check("irq_ack_and_press_hold", 64'(irq_req), 64'(1));
    irq_ack = 1'b1;
    tick;
    irq_ack = 1'b0;
    check("irq_ack_clear3", 64'(irq_req), 64'(0));

    // Reset in the middle of a step with an interrupt pending
    do_reset(1'b1);
    repeat (RST_LEN + 2) tick;
    check("dbg_rst2_halted", 64'(halted), 64'(1));
    press(M_IRQ);
    tick;
    check("irq_pending", 64'(irq_req), 64'(1));
    press(M_STEP);
    tick;
    check("step_started", 64'(cpu_en), 64'(1));
    tick;
    check("step_mid_count", 64'(step_count), 64'(1));
    rstn = 1'b0;
    tick;
    check("midstep_rst_cpu_en", 64'(cpu_en), 64'(0));
    check("midstep_rst_irq_req", 64'(irq_req), 64'(0));
    check("midstep_rst_count", 64'(step_count), 64'(0));
    check("midstep_rst_rst_out", 64'(rst_out), 64'(1));
    check("midstep_rst_halted", 64'(halted), 64'(0));
    rstn = 1'b1;
    repeat (RST_LEN + 2) tick;
    check("post_rst_halted", 64'({cpu_en, halted}), 64'(2'b01));
    check("post_rst_count", 64'(step_count), 64'(0));

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
